// File: rtl/pcie_dma_fifo.sv
// pcie_dma_fifo: first-word-fall-through ready/valid FIFO carrying
// {last, strb, data} beats between the PCIe endpoint and the DMA master.
// Tracks occupancy, complete packets held, almost-full, and sticky
// overflow/underflow diagnostics. A flush empties the FIFO but keeps the flags.
module pcie_dma_fifo #(
    parameter int dbits          = 64,
    parameter int log2_depth     = 1,
    parameter int almfull_thresh = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_wvalid,
    output logic                  o_wready,
    input  logic [dbits-1:0]      i_wdata,
    input  logic [dbits/8-1:0]    i_wstrb,
    input  logic                  i_wlast,
    output logic                  o_rvalid,
    input  logic                  i_rready,
    output logic [dbits-1:0]      o_rdata,
    output logic [dbits/8-1:0]    o_rstrb,
    output logic                  o_rlast,
    output logic [log2_depth:0]   o_count,
    output logic [log2_depth:0]   o_pkt_cnt,
    output logic                  o_almfull,
    output logic                  o_ovf,
    output logic                  o_unf
);

    localparam int depth = 2 ** log2_depth;
    localparam int sbits = dbits / 8;
    localparam int ebits = dbits + sbits + 1;
    localparam logic [log2_depth:0]   full_lvl = (log2_depth + 1)'(depth);
    localparam logic [log2_depth:0]   alm_lvl  = (log2_depth + 1)'(depth - almfull_thresh);
    localparam logic [log2_depth:0]   cnt_one  = (log2_depth + 1)'(1);
    localparam logic [log2_depth-1:0] ptr_one  = (log2_depth)'(1);

    logic [ebits-1:0]      mem [depth];
    logic [log2_depth-1:0] wr_ptr;
    logic [log2_depth-1:0] rd_ptr;
    logic [log2_depth:0]   count;
    logic [log2_depth:0]   count_next;
    logic [log2_depth:0]   pkt_cnt;
    logic [log2_depth:0]   pkt_next;
    logic                  almfull;
    logic                  ovf;
    logic                  unf;
    logic                  do_write;
    logic                  do_read;
    logic                  wr_last;
    logic                  rd_last;
    logic [ebits-1:0]      head;

    // Status comes only from registers, so wready never depends on rready.
    assign o_wready  = (count != full_lvl);
    assign o_rvalid  = (count != '0);
    assign head      = mem[rd_ptr];
    assign o_rlast   = head[ebits-1];
    assign o_rstrb   = head[dbits +: sbits];
    assign o_rdata   = head[dbits-1:0];
    assign o_count   = count;
    assign o_pkt_cnt = pkt_cnt;
    assign o_almfull = almfull;
    assign o_ovf     = ovf;
    assign o_unf     = unf;

    // A flush swallows any handshake in the same cycle.
    assign do_write = i_wvalid && o_wready && !i_flush;
    assign do_read  = o_rvalid && i_rready && !i_flush;
    assign wr_last  = do_write && i_wlast;
    assign rd_last  = do_read && o_rlast;

    // Next occupancy and packet count; simultaneous in/out cancel out.
    always_comb begin
        count_next = count;
        pkt_next   = pkt_cnt;
        if (i_flush) begin
            count_next = '0;
            pkt_next   = '0;
        end else begin
            if (do_write && !do_read) begin
                count_next = count + cnt_one;
            end else if (!do_write && do_read) begin
                count_next = count - cnt_one;
            end
            if (wr_last && !rd_last) begin
                pkt_next = pkt_cnt + cnt_one;
            end else if (!wr_last && rd_last) begin
                pkt_next = pkt_cnt - cnt_one;
            end
        end
    end

    // Pointers, counters, almost-full and sticky diagnostic flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            pkt_cnt <= '0;
            almfull <= 1'b0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
        end else begin
            if (i_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_write) begin
                    wr_ptr <= wr_ptr + ptr_one;
                end
                if (do_read) begin
                    rd_ptr <= rd_ptr + ptr_one;
                end
            end
            count   <= count_next;
            pkt_cnt <= pkt_next;
            almfull <= (count_next >= alm_lvl);
            if (i_wvalid && !o_wready) begin
                ovf <= 1'b1;
            end
            if (i_rready && !o_rvalid) begin
                unf <= 1'b1;
            end
        end
    end

    // Storage array; contents are not reset and are only meaningful while held.
    always_ff @(posedge i_clk) begin
        if (do_write) begin
            mem[wr_ptr] <= {i_wlast, i_wstrb, i_wdata};
        end
    end

endmodule

// File: doc/pcie_dma_fifo.md
Name: pcie_dma_fifo

Overview:
- Parametrised ready/valid FIFO for the PCIe DMA engine; replaces the fixed 64-bit, 2-entry DMA buffering with generic data width and power-of-two depth.
- Adds byte strobes and a last flag per entry, occupancy and almost-full status, a count of complete packets held, synchronous flush, and sticky overflow/underflow flags.
- Sits between the PCIe endpoint TLP data path and the DMA AXI/bus master, in both directions.

Parameters:
- dbits, 64, data width in bits; multiple of 8.
- log2_depth, 1, FIFO depth = 2**log2_depth entries; legal range 1..10.
- almfull_thresh, 1, o_almfull asserts when count >= (2**log2_depth - almfull_thresh).

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_flush  in  1  synchronous clear of contents and counters; sticky flags are kept.
- i_wvalid  in  1  write data valid.
- o_wready  out  1  FIFO can accept a write.
- i_wdata  in  dbits  write data.
- i_wstrb  in  dbits/8  write byte enables.
- i_wlast  in  1  last beat of a packet.
- o_rvalid  out  1  read data valid.
- i_rready  in  1  consumer accepts o_rdata.
- o_rdata  out  dbits  head-entry data.
- o_rstrb  out  dbits/8  head-entry byte enables.
- o_rlast  out  1  head-entry last flag.
- o_count  out  log2_depth+1  number of entries held.
- o_pkt_cnt  out  log2_depth+1  number of entries with last=1 held.
- o_almfull  out  1  almost-full status.
- o_ovf  out  1  sticky: write attempted while full.
- o_unf  out  1  sticky: read attempted while empty.

Behaviour:
- Storage is a register/RAM array of {last, strb, data}, with wr_ptr and rd_ptr of log2_depth bits that wrap naturally modulo depth, plus a count register.
- Handshakes:
  - A write occurs on a cycle with wvalid && wready.
  - A read occurs on a cycle with rvalid && rready.
  - wvalid must stay high with stable data until the write is accepted; the bench checks this.
- o_wready = (count != depth). It derives only from registers, so there is no combinational path from i_rready.
  - When full, a write is refused even if a read occurs in the same cycle.
- The output is first-word-fall-through.
  - o_rvalid = (count != 0).
  - o_rdata, o_rstrb and o_rlast show mem[rd_ptr] combinationally from registered state.
  - Write-to-read latency is 1 cycle: data written at edge N is visible as o_rvalid after edge N.
- Count update: +1 on write only, -1 on read only, unchanged when both occur.
  - Simultaneous read and write at count=0 cannot happen, because rvalid is 0.
- pkt_cnt update: +1 when the written beat has wlast=1; -1 when the read beat has rlast=1; both in the same cycle leave it unchanged.
- o_almfull is registered from the next-state count; it changes on the same edge as o_count.
- o_ovf sets when i_wvalid && !o_wready. o_unf sets when i_rready && !o_rvalid.
  - Both are cleared only by i_rst. They are diagnostic, and the data path is unaffected.
- i_flush:
  - Sets ptrs, count and pkt_cnt to 0 on the next edge.
  - Has priority over a concurrent write or read in the same cycle; that write is dropped and is not counted as accepted.
- Reset values:
  - o_count=0, o_pkt_cnt=0, o_rvalid=0, o_wready=1 (from count=0), o_almfull=0, o_ovf=0, o_unf=0, pointers 0.
  - o_rdata, o_rstrb and o_rlast are don't-care while o_rvalid=0; memory contents are not reset.
- Reset mid-transfer discards all contents; i_rst has priority over i_flush.

Test Plan:
- Reset, then 4 writes of 0x1111..0x4444 with default params (depth 2): the first two are accepted; wready=0 after the 2nd; o_ovf=1 while wvalid is held on full; count=2; almfull=1 at count>=1. Drain → reads 0x1111, 0x2222 in order.
- log2_depth=3, dbits=128: 20 back-to-back writes and reads with random rready (50%) → output order is identical and no loss; pointers wrap twice; count never exceeds 8.
- Write 3 beats, last on the 3rd, then 2 beats, last on the 2nd → pkt_cnt=2. Read 3 beats → pkt_cnt=1 and count=2; o_rlast=1 on the 3rd read.
- Steady state count=4 with simultaneous write+read for 10 cycles → count stays 4 and almfull is stable; wstrb=0x0F per beat is reproduced exactly on o_rstrb.
- Count=5, assert i_flush together with wvalid=1 → next cycle count=0, pkt_cnt=0, rvalid=0; the flush-cycle data never appears; o_ovf/o_unf are unchanged.
- i_rready=1 while empty after reset → o_unf=1 and count stays 0. Assert i_rst with count=3 → all outputs return to reset values in 1 cycle.
